// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide run over WIDTH clocks on a shared 2*WIDTH accumulator.
module muldiv_hilo_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic               is_div;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;

  // Operand conditioning at launch: op[0]=0 selects the signed variants.
  logic             in_a_neg, in_b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign in_a_neg = ~op[0] & src_a[WIDTH-1];
  assign in_b_neg = ~op[0] & src_b[WIDTH-1];
  assign abs_a    = in_a_neg ? -src_a : src_a;
  assign abs_b    = in_b_neg ? -src_b : src_b;

  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi, res_lo;

  // For MUL, acc = {partial sum, remaining multiplier bits} and opnd is the multiplicand.
  // For DIV, acc = {partial remainder, remaining dividend/quotient bits} and opnd is the divisor.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    acc_next  = acc;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opnd};
    if (is_div) begin
      if (div_diff[WIDTH])
        acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
        acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Sign correction of the result produced by the final iteration.
  // A zero divisor leaves quotient all-ones and remainder |a|; re-signing the remainder restores src_a.
  always_comb begin
    prod   = (a_neg ^ b_neg) ? -acc_next : acc_next;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div) begin
      res_hi = a_neg ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
      if (opnd == '0)
        res_lo = '1;
      else
        res_lo = (a_neg ^ b_neg) ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      is_div <= 1'b0;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div <= op[1];
            a_neg  <= in_a_neg;
            b_neg  <= in_b_neg;
            opnd   <= op[1] ? abs_b : abs_a;
            acc    <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
            cnt    <= '0;
            state  <= RUN;
          end else begin
            if (hi_we) hi <= wd;
            if (lo_we) lo <= wd;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            hi    <= res_hi;
            lo    <= res_lo;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Scoreboard bench for muldiv_hilo_unit: driver pushes expected HI/LO and completion cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_hilo_unit;

  localparam int WIDTH = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        op = 2'b00;
  logic [WIDTH-1:0]  src_a = '0;
  logic [WIDTH-1:0]  src_b = '0;
  logic              hi_we = 1'b0;
  logic              lo_we = 1'b0;
  logic [WIDTH-1:0]  wd = '0;
  logic [WIDTH-1:0]  hi, lo;
  logic              busy, done;

  muldiv_hilo_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .hi_we(hi_we), .lo_we(lo_we), .wd(wd), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          busy_cnt = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic following the MIPS HI/LO rules.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    int          ia, ib;
    longint      sp;
    logic [63:0] p;
    ia = a;
    ib = b;
    h = '0;
    l = '0;
    case (o)
      2'b00: begin
        sp = longint'(ia) * longint'(ib);
        p = sp;
        {h, l} = p;
      end
      2'b01: begin
        p = {32'b0, a} * {32'b0, b};
        {h, l} = p;
      end
      2'b10: begin
        if (b == 32'h0) begin
          h = a; l = 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          h = 32'h0; l = 32'h8000_0000;
        end else begin
          l = ia / ib;
          h = ia % ib;
        end
      end
      default: begin
        if (b == 32'h0) begin
          h = a; l = 32'hFFFF_FFFF;
        end else begin
          l = a / b;
          h = a % b;
        end
      end
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        check("done_while_busy", 64'(busy), 64'(0));
        if (sb_q.size() == 0) begin
          check("unexpected_done", 64'(done), 64'(0));
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("hi", 64'(hi), 64'(e.hi));
          check("lo", 64'(lo), 64'(e.lo));
          check("latency_edge", 64'(cyc), 64'(e.cyc));
          check("busy_cycles", 64'(busy_cnt), 64'(WIDTH));
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    check("idle_timeout", 64'(busy), 64'(0));
  endtask

  // Launch one operation from a negedge; returns after the start edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    model(o, a, b, e.hi, e.lo);
    e.cyc = cyc + 1 + WIDTH;
    sb_q.push_back(e);
    last_hi = e.hi;
    last_lo = e.lo;
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    wait_idle();
    issue(o, a, b);
    wait_idle();
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    rst = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op(2'b11, 32'd100, 32'd7);
    run_op(2'b11, 32'h0000_1234, 32'h0);
    run_op(2'b10, 32'hFFFF_FF00, 32'h0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE);

    // Start and MTHI while busy are both ignored
    wait_idle();
    issue(2'b01, 32'd6, 32'd7);
    repeat (3) @(negedge clk);
    src_a = 32'd123; src_b = 32'd456; op = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    wd = 32'hDEAD_BEEF; hi_we = 1'b1;
    @(negedge clk);
    hi_we = 1'b0;
    wait_idle();
    @(negedge clk);
    check("ignored_busy_hi", 64'(hi), 64'(32'h0));
    check("ignored_busy_lo", 64'(lo), 64'(32'd42));

    // MTHI in IDLE
    wd = 32'hA5A5_A5A5; hi_we = 1'b1;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_hi", 64'(hi), 64'(32'hA5A5_A5A5));
    check("mthi_lo_kept", 64'(lo), 64'(last_lo));
    wd = 32'h5A5A_0F0F; lo_we = 1'b1;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_lo", 64'(lo), 64'(32'h5A5A_0F0F));
    check("mtlo_hi_kept", 64'(hi), 64'(32'hA5A5_A5A5));

    // Start wins over MTLO in the same cycle
    wd = 32'h1111_1111; lo_we = 1'b1;
    issue(2'b11, 32'd100, 32'd7);
    lo_we = 1'b0;
    check("start_wins_lo", 64'(lo), 64'(32'h5A5A_0F0F));
    check("start_busy", 64'(busy), 64'(1));
    wait_idle();

    // Randomised mix
    for (int n = 0; n < 40; n++)
      run_op(2'($urandom_range(0, 3)), rand_operand(), rand_operand());

    // Asynchronous reset mid-operation
    wait_idle();
    issue(2'b10, 32'hFFFF_F000, 32'd13);
    repeat (14) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_hi", 64'(hi), 64'(0));
    check("async_rst_lo", 64'(lo), 64'(0));
    check("async_rst_busy", 64'(busy), 64'(0));
    check("async_rst_done", 64'(done), 64'(0));
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op(2'b11, 32'd9, 32'd3);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
